// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the multiply/divide execution unit:
//   - req_op operation encodings
//   - fwd_sel operand-source encodings
//   - FSM state enumeration
//   - small decode helpers used by the datapath
// ----------------------------------------------------------------------------
package exec_pkg;

    // Operation codes carried on req_op
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    // Operand source selects carried on fwd_sel_a / fwd_sel_b
    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // True for the two divide operations
    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the two signed operations
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// ----------------------------------------------------------------------------
// operand_fwd_mux
// Selects one execution operand from the register file or one of the two
// forwarding paths.
//   i_sel   : source select (00 reg, 01 wb, 10 mem, 11 reg)
//   i_reg   : register-file value
//   i_wb    : write-back stage forwarded value
//   i_mem   : memory stage forwarded value
//   o_data  : selected operand
// ----------------------------------------------------------------------------
module operand_fwd_mux
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_wb,
    input  logic [DATA_W-1:0] i_mem,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_reg;
        case (i_sel)
            FWD_WB:  o_data = i_wb;
            FWD_MEM: o_data = i_mem;
            default: o_data = i_reg;   // 00 and 11 both take the register file
        endcase
    end

endmodule

// File: rtl/exec_muldiv.sv
// ----------------------------------------------------------------------------
// exec_muldiv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// All state changes on the falling edge of clk; rst is asynchronous.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   stop_debug         : freezes every register while high
//   req_valid, req_op  : request strobe and operation code
//   reg_a, reg_b       : register-file operands
//   mem_result         : memory-stage forwarded value
//   wb_result          : write-back-stage forwarded value
//   fwd_sel_a/b        : operand source selects
//   busy               : an operation is in flight (FSM not IDLE)
//   stall              : request present while busy; requester must hold it
//   done               : one-cycle completion pulse
//   div_by_zero        : pulses with done when a divide had a zero divisor
//   hi, lo             : architectural HI/LO
//   rd_data            : MFHI/MFLO read value (hi for MFHI, otherwise lo)
//
// Handshake: a request is taken on a falling edge with req_valid=1, busy=0
// and stop_debug=0. While busy, stall=req_valid and the request is ignored.
// ----------------------------------------------------------------------------
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop_debug,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [1:0]        fwd_sel_a,
    input  logic [1:0]        fwd_sel_b,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] rd_data
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
        .i_sel  (fwd_sel_a),
        .i_reg  (reg_a),
        .i_wb   (wb_result),
        .i_mem  (mem_result),
        .o_data (w_opa)
    );

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
        .i_sel  (fwd_sel_b),
        .i_reg  (reg_b),
        .i_wb   (wb_result),
        .i_mem  (mem_result),
        .o_data (w_opb)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_work_hi;   // partial product high half / remainder
    logic [DATA_W-1:0] r_work_lo;   // multiplier shifting out / quotient shifting in
    logic [DATA_W-1:0] r_opnd_b;    // multiplicand or divisor magnitude
    logic              r_is_div;
    logic              r_is_signed;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_dbz;       // pending operation is a divide by zero
    logic              r_done;
    logic              r_dbz_out;

    // ------------------------------------------------------------------
    // Combinational control and datapath
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_signed_op;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_prod_neg;
    logic [DATA_W-1:0]   w_quo_neg;
    logic [DATA_W-1:0]   w_rem_neg;

    assign busy     = (r_state != ST_IDLE);
    assign stall    = req_valid & busy;
    assign w_accept = req_valid & ~busy & ~stop_debug;

    always_comb begin
        w_signed_op = op_is_signed(req_op);
        w_sign_a    = w_signed_op & w_opa[DATA_W-1];
        w_sign_b    = w_signed_op & w_opb[DATA_W-1];
        // The most-negative value maps to itself, which is its correct
        // unsigned magnitude.
        w_abs_a     = w_sign_a ? -w_opa : w_opa;
        w_abs_b     = w_sign_b ? -w_opb : w_opb;

        // Multiply step: conditionally add multiplicand into the high half,
        // then shift the whole product right by one (carry enters the top).
        w_sum = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opnd_b} : {(DATA_W+1){1'b0}});

        // Restoring divide step: shift next dividend bit into the remainder
        // and trial-subtract. Because remainder < divisor, a nonnegative
        // difference never sets the top bit, so w_diff[DATA_W] is the borrow.
        w_shift = {r_work_hi, r_work_lo[DATA_W-1]};
        w_diff  = w_shift - {1'b0, r_opnd_b};

        w_prod_neg = -{r_work_hi, r_work_lo};
        w_quo_neg  = -r_work_lo;
        w_rem_neg  = -r_work_hi;
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_work_hi   <= '0;
            r_work_lo   <= '0;
            r_opnd_b    <= '0;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
            r_dbz_out   <= 1'b0;
        end else if (!stop_debug) begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (req_op)
                            OP_MTHI: r_hi <= w_opa;
                            OP_MTLO: r_lo <= w_opa;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_is_div    <= op_is_div(req_op);
                                r_is_signed <= w_signed_op;
                                r_sign_a    <= w_sign_a;
                                r_sign_b    <= w_sign_b;
                                r_work_hi   <= '0;
                                r_work_lo   <= w_abs_a;
                                r_opnd_b    <= w_abs_b;
                                if (op_is_div(req_op) && (w_opb == '0)) begin
                                    // Skip the iterations; FIX only signals.
                                    r_dbz   <= 1'b1;
                                    r_state <= ST_FIX;
                                end else begin
                                    r_dbz   <= 1'b0;
                                    r_cnt   <= CNT_LOAD;
                                    r_state <= ST_RUN;
                                end
                            end
                            default: ;   // MFHI/MFLO are served by rd_data
                        endcase
                    end
                end

                ST_RUN: begin
                    if (r_is_div) begin
                        if (w_diff[DATA_W]) begin
                            r_work_hi <= w_shift[DATA_W-1:0];
                            r_work_lo <= {r_work_lo[DATA_W-2:0], 1'b0};
                        end else begin
                            r_work_hi <= w_diff[DATA_W-1:0];
                            r_work_lo <= {r_work_lo[DATA_W-2:0], 1'b1};
                        end
                    end else begin
                        r_work_hi <= w_sum[DATA_W:1];
                        r_work_lo <= {w_sum[0], r_work_lo[DATA_W-1:1]};
                    end
                    r_cnt <= r_cnt - CNT_LAST;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_dbz) begin
                        r_dbz_out <= 1'b1;
                    end else if (r_is_div) begin
                        r_lo <= (r_is_signed && (r_sign_a ^ r_sign_b)) ? w_quo_neg : r_work_lo;
                        r_hi <= (r_is_signed && r_sign_a) ? w_rem_neg : r_work_hi;
                    end else if (r_is_signed && (r_sign_a ^ r_sign_b)) begin
                        {r_hi, r_lo} <= w_prod_neg;
                    end else begin
                        r_hi <= r_work_hi;
                        r_lo <= r_work_lo;
                    end
                    r_dbz   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign rd_data     = (req_op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: doc/exec_muldiv.md
EXEC_MULDIV -- requirements
Module: exec_muldiv

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-high; all other state SHALL update on the falling edge of clk.
REQ-002 Parameter DATA_W, default 32, SHALL set the operand, HI and LO width; CNT_W = clog2(DATA_W+1) SHALL be derived locally.
REQ-003 Ports SHALL be as follows, one per line:
- clk  in  1  clock
- rst  in  1  async active-high reset
- stop_debug  in  1  freeze all state
- req_valid  in  1  request present
- req_op  in  3  operation code
- reg_a, reg_b  in  DATA_W  register-file operands
- mem_result, wb_result  in  DATA_W  forwarded values
- fwd_sel_a, fwd_sel_b  in  2  operand source select
- busy  out  1  operation in flight
- stall  out  1  request refused, hold it
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  pulse together with done
- hi, lo  out  DATA_W  architectural HI/LO
- rd_data  out  DATA_W  MFHI/MFLO result

Function
REQ-004 req_op encoding SHALL be: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO.
REQ-005 The operand source SHALL be selected per fwd_sel: 00 reg, 01 wb_result, 10 mem_result, 11 reg.
REQ-006 A request SHALL be accepted on a falling edge where req_valid=1, busy=0 and stop_debug=0.
REQ-007 stall SHALL equal req_valid AND busy, combinationally; a stalled request SHALL be ignored and have no side effect.
REQ-008 The FSM SHALL have the states IDLE, RUN and FIX; busy SHALL be 1 in any state other than IDLE.
REQ-009 On acceptance of MULT/MULTU/DIV/DIVU with a nonzero divisor, the FSM SHALL:
- latch the operand magnitudes (absolute values for signed ops) and the operand signs;
- load the iteration counter with DATA_W;
- enter RUN.
REQ-010 RUN SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per edge, for DATA_W edges, then enter FIX.
REQ-011 The FIX edge SHALL apply the sign correction, write HI/LO, set done=1 for exactly one cycle and return to IDLE.
REQ-012 Total latency SHALL be: accepted at edge E, HI/LO updated and done=1 after edge E+DATA_W+1, with busy=0 in that same cycle.
REQ-013 Result rules SHALL be:
- multiply: the 2*DATA_W-bit product goes to {hi,lo};
- divide: the quotient goes to lo and the remainder to hi;
- signed divide: the quotient is negated when the signs differ, and the remainder takes the sign of the dividend;
- most-negative / -1: lo = most-negative, hi = 0 (two's-complement wrap).
REQ-014 On acceptance of DIV/DIVU with a divisor of 0, the block SHALL skip RUN, leave HI/LO unchanged, and assert done and div_by_zero for one cycle after the next edge.
REQ-015 MTHI/MTLO SHALL write the selected forwarded operand A to hi/lo on the accepting edge, without entering busy and without asserting done.
REQ-016 rd_data SHALL be combinational: hi when req_op=110, otherwise lo; it is valid only while stall=0.
REQ-017 While stop_debug=1, every register (including FSM, counter and done) SHALL hold its value; stall SHALL still follow REQ-007.

Reset
REQ-018 On rst, the block SHALL immediately enter IDLE with hi=0, lo=0, busy=0, done=0, div_by_zero=0 and counter=0, aborting any operation in progress with no partial HI/LO write.
REQ-019 After rst deasserts, the first request SHALL be accepted on the next qualifying falling edge.

Structure
REQ-020 A shared package exec_pkg SHALL hold the req_op encodings, the fwd_sel encodings and the FSM state enum.
REQ-021 A sub-module operand_fwd_mux SHALL implement REQ-005 and be instantiated twice, once for A and once for B.

Verification
REQ-022 The bench SHALL cover the following directed scenarios at DATA_W=32:
- MULT 0xFFFFFFFD x 7 -> after 33 edges, hi=0xFFFFFFFF, lo=0xFFFFFFEB, done high exactly one cycle.
- DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- MTHI 0x1234, MTLO 0x5678, then DIVU x/0 -> one edge later done=div_by_zero=1, and hi/lo still 0x1234/0x5678.
- fwd_sel_a=10 with mem_result=5 and reg_a=9, MULTU b=3 -> lo=15, hi=0.
- MFLO issued during RUN -> stall=1 until done, then rd_data=lo and the request is accepted.
- rst asserted mid-RUN -> busy=0 and hi=lo=0 without a clock edge; a subsequent MULT 2x3 gives lo=6.
